satd_sequencer: RTL and testbench
=================================

Name: satd_sequencer

Overview:
- Control FSM that schedules one 8x8 SATD block through the datapath in order: differences, horizontal Hadamard, transpose buffer, vertical Hadamard, absolute sum.
- Accepts a start/ready handshake and drives the row index used to slice ORG/CUR.
- Generates delay-aligned enables for every stage and pulses done when the accumulated SATD is stable.
- Replaces the free-running counter plus control_satd pairing in the SATD top.

Parameters:
- ROWS, 8: rows per block (ITERATIONS+1); legal range 2..16.
- HT_LAT, 2: horizontal transform latency in cycles, from ena_ht_h to valid output; must be >= 1.
- VT_LAT, 2: vertical transform latency in cycles, from ena_ht_v to valid output; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request to process one block
- ready  out  1  high only in IDLE; start is accepted when start&ready
- row_idx  out  4  row slice select for ORG/CUR
- ena_diff  out  1  differences stage enable
- ena_ht_h  out  1  horizontal transform enable
- sel_ht_h  out  1  high on the first row of a block; clears ht_h internal state
- tbuf_wr  out  1  transpose buffer write strobe
- tbuf_wr_row  out  4  transpose buffer write row
- tbuf_rd  out  1  transpose buffer column read strobe
- tbuf_rd_col  out  4  transpose buffer read column
- ena_ht_v  out  1  vertical transform enable
- ena_sum  out  1  absolute-sum accumulate enable
- rst_sum  out  1  clears the sum accumulator
- done  out  1  one-cycle pulse; sum output valid this cycle

Behaviour:
- States: IDLE, LOAD, DRAIN_H, VERT, DRAIN_V, DONE. Moore outputs decoded from state, the phase counter and the delay lines.
- Reset: state=IDLE; counters and delay lines = 0. All outputs 0 except ready=1 and rst_sum=1. Reset mid-block aborts the block; idle values appear on the cycle after the reset edge.
- IDLE: ready=1, rst_sum=1. start&ready moves to LOAD and clears the phase counter. start when not ready is ignored; there is no queuing.
- LOAD: lasts ROWS cycles. ena_diff=ena_ht_h=1. row_idx = phase counter, 0..ROWS-1. sel_ht_h=1 only when row_idx==0. On the last row, go to DRAIN_H and clear the counter.
- tbuf_wr is ena_ht_h delayed by HT_LAT cycles through a shift register. tbuf_wr_row increments on each write, starts at 0 per block and wraps to 0 after ROWS-1.
- DRAIN_H: lasts HT_LAT cycles. Go to VERT once all ROWS writes have occurred.
- VERT: lasts ROWS cycles. tbuf_rd=ena_ht_v=1; tbuf_rd_col = counter.
- ena_sum is ena_ht_v delayed by VT_LAT cycles.
- DRAIN_V: lasts VT_LAT cycles, then DONE.
- DONE: lasts 1 cycle. done=1, ready=0, ena_sum=0 so the sum holds. Then IDLE; rst_sum reasserts from the next cycle.
- Latency: with the accept cycle as 0, done occurs in cycle 2*ROWS+HT_LAT+VT_LAT+1 (21 with defaults). Back-to-back blocks therefore have a period of 22 cycles.
- Counters are 4 bits. Terminal compare is against ROWS-1, so a counter never reaches ROWS.
- Exactly ROWS tbuf_wr pulses and ROWS ena_sum pulses occur per block.

Optional Feature:
- Macro: SATD_BLK_CNT_EN.
- Defined: adds output blk_count[15:0], reset to 0, incremented in the DONE cycle, wrapping 0xFFFF->0. Not cleared by an aborted block.
- Undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package satd_pkg holds:
  - state typedef satd_state_t, encoded IDLE=0, LOAD=1, DRAIN_H=2, VERT=3, DRAIN_V=4, DONE=5;
  - default latency constants SATD_HT_LAT=2, SATD_VT_LAT=2, SATD_ROWS=8;
  - row index width constant SATD_IDX_W=4.
- Sub-module satd_delay_line (parameter DEPTH, 1-bit, synchronous clear on rst). Instantiated twice: tbuf_wr alignment and ena_sum alignment.

Test Plan:
- Reset then idle: after rst, ready=1, rst_sum=1, all other outputs 0; hold 10 cycles, nothing changes.
- Single block with defaults: start pulse accepted at cycle 0.
  - row_idx 0..7 in cycles 1..8; sel_ht_h only in cycle 1.
  - tbuf_wr in cycles 3..10 with rows 0..7.
  - tbuf_rd_col 0..7 in cycles 11..18; ena_sum in cycles 13..20.
  - done in cycle 21; ready=1 in cycle 22.
- Start while busy: start held high continuously. Second accept occurs in cycle 22; no pulse in cycles 1..21 is duplicated.
- Reset mid-operation: rst asserted in cycle 12 (VERT). Cycle 13 shows IDLE values, ena_sum=0, no done. A new start then completes a normal 21-cycle block.
- Parameter sweep: ROWS=4, HT_LAT=1, VT_LAT=3. done in cycle 13, exactly 4 tbuf_wr and 4 ena_sum pulses.
- With SATD_BLK_CNT_EN defined: run 3 blocks, blk_count=3. Preload near wrap by forcing 0xFFFF; after the next DONE, blk_count=0.

Source files
------------

// File: rtl/satd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : satd_pkg                                                  |
// | Purpose  : Shared types and default constants for the SATD block     |
// |            sequencer (state encoding, latencies, index width).       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package satd_pkg;

  // Sequencer states; encoding is fixed so other blocks may decode it.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DRAIN_H = 3'd2,
    VERT    = 3'd3,
    DRAIN_V = 3'd4,
    DONE    = 3'd5
  } satd_state_t;

  localparam int SATD_HT_LAT = 2;
  localparam int SATD_VT_LAT = 2;
  localparam int SATD_ROWS   = 8;
  localparam int SATD_IDX_W  = 4;

endpackage : satd_pkg
`default_nettype wire

// File: rtl/satd_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : satd_delay_line                                           |
// | Purpose  : 1-bit shift register delaying an enable by DEPTH cycles;  |
// |            synchronously cleared by rst so an aborted block leaves   |
// |            no stale pulses in flight.                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module satd_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o
);

  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_single
      // Single-stage delay: one register.
      always_ff @(posedge clk) begin
        if (rst) sr_q <= 1'b0;
        else     sr_q <= din_i;
      end
    end else begin : g_chain
      // Multi-stage delay: shift toward the MSB, output from the MSB.
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= {sr_q[DEPTH-2:0], din_i};
      end
    end
  endgenerate

  assign dout_o = sr_q[DEPTH-1];

endmodule : satd_delay_line
`default_nettype wire

// File: rtl/satd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : satd_sequencer                                            |
// | Purpose  : Control FSM that walks one 8x8 SATD block through the     |
// |            diff / H-Hadamard / transpose / V-Hadamard / abs-sum      |
// |            datapath, producing delay-aligned stage enables and a     |
// |            one-cycle done pulse.                                     |
// | Options  : SATD_BLK_CNT_EN adds a 16-bit completed-block counter.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module satd_sequencer
  import satd_pkg::*;
#(
  parameter int ROWS   = SATD_ROWS,
  parameter int HT_LAT = SATD_HT_LAT,
  parameter int VT_LAT = SATD_VT_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  ready_o,
  output logic [SATD_IDX_W-1:0] row_idx_o,
  output logic                  ena_diff_o,
  output logic                  ena_ht_h_o,
  output logic                  sel_ht_h_o,
  output logic                  tbuf_wr_o,
  output logic [SATD_IDX_W-1:0] tbuf_wr_row_o,
  output logic                  tbuf_rd_o,
  output logic [SATD_IDX_W-1:0] tbuf_rd_col_o,
  output logic                  ena_ht_v_o,
  output logic                  ena_sum_o,
  output logic                  rst_sum_o,
`ifdef SATD_BLK_CNT_EN
  output logic [15:0]           blk_count_o,
`endif
  output logic                  done_o
);

  // Terminal counts; counters stop one short of ROWS / VT_LAT.
  localparam logic [SATD_IDX_W-1:0] c_ROW_LAST = SATD_IDX_W'(ROWS - 1);
  localparam logic [SATD_IDX_W-1:0] c_VT_LAST  = SATD_IDX_W'(VT_LAT - 1);

  satd_state_t           state_q, state_d;
  logic [SATD_IDX_W-1:0] cnt_q, cnt_d;
  logic [SATD_IDX_W-1:0] wr_row_q, wr_row_d;
  logic                  w_tbuf_wr;
  logic                  w_sum_dly;

  // Align the transpose-buffer write with the horizontal transform output.
  satd_delay_line #(.DEPTH(HT_LAT)) u_dly_wr (
    .clk    (clk),
    .rst    (rst),
    .din_i  (ena_ht_h_o),
    .dout_o (w_tbuf_wr)
  );

  // Align the accumulate enable with the vertical transform output.
  satd_delay_line #(.DEPTH(VT_LAT)) u_dly_sum (
    .clk    (clk),
    .rst    (rst),
    .din_i  (ena_ht_v_o),
    .dout_o (w_sum_dly)
  );

  // State, phase counter and write-row register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_row_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_row_q <= wr_row_d;
    end
  end

  // Write row advances per write and wraps so each block starts at row 0.
  always_comb begin
    wr_row_d = wr_row_q;
    if (state_q == IDLE)
      wr_row_d = '0;
    else if (w_tbuf_wr)
      wr_row_d = (wr_row_q == c_ROW_LAST) ? '0 : wr_row_q + 1'b1;
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ready_o       = 1'b0;
    rst_sum_o     = 1'b0;
    ena_diff_o    = 1'b0;
    ena_ht_h_o    = 1'b0;
    sel_ht_h_o    = 1'b0;
    row_idx_o     = '0;
    tbuf_rd_o     = 1'b0;
    tbuf_rd_col_o = '0;
    ena_ht_v_o    = 1'b0;
    done_o        = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o   = 1'b1;
        rst_sum_o = 1'b1;
        if (start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        ena_diff_o = 1'b1;
        ena_ht_h_o = 1'b1;
        row_idx_o  = cnt_q;
        sel_ht_h_o = (cnt_q == '0);
        if (cnt_q == c_ROW_LAST) begin
          state_d = DRAIN_H;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN_H: begin
        // The last delayed write closes the horizontal drain.
        cnt_d = '0;
        if (w_tbuf_wr && (wr_row_q == c_ROW_LAST))
          state_d = VERT;
      end
      VERT: begin
        tbuf_rd_o     = 1'b1;
        ena_ht_v_o    = 1'b1;
        tbuf_rd_col_o = cnt_q;
        if (cnt_q == c_ROW_LAST) begin
          state_d = DRAIN_V;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN_V: begin
        if (cnt_q == c_VT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tbuf_wr_o     = w_tbuf_wr;
  assign tbuf_wr_row_o = wr_row_q;
  // Sum must hold while done is presented.
  assign ena_sum_o     = w_sum_dly && (state_q != DONE);

`ifdef SATD_BLK_CNT_EN
  logic [15:0] blk_count_q;

  // Completed-block counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)                  blk_count_q <= '0;
    else if (state_q == DONE) blk_count_q <= blk_count_q + 16'd1;
  end

  assign blk_count_o = blk_count_q;
`endif

endmodule : satd_sequencer
`default_nettype wire

// File: tb/tb_satd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_satd_sequencer                                         |
// | Purpose  : Directed self-checking bench for satd_sequencer: default  |
// |            instance plus a ROWS=4/HT_LAT=1/VT_LAT=3 instance.        |
// |            Blocks under SATD_BLK_CNT_EN exercise the block counter.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_satd_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start1, start2;

  logic       rdy1, ediff1, ehh1, sel1, wr1, rd1, ehv1, esum1, rsum1, done1;
  logic [3:0] row1, wrow1, rcol1;
  logic       rdy2, ediff2, ehh2, sel2, wr2, rd2, ehv2, esum2, rsum2, done2;
  logic [3:0] row2, wrow2, rcol2;
`ifdef SATD_BLK_CNT_EN
  logic [15:0] bc1, bc2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int wr2_cnt, sum2_cnt;

  always #5 clk = ~clk;

  satd_sequencer dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .ready_o(rdy1), .row_idx_o(row1),
    .ena_diff_o(ediff1), .ena_ht_h_o(ehh1), .sel_ht_h_o(sel1), .tbuf_wr_o(wr1),
    .tbuf_wr_row_o(wrow1), .tbuf_rd_o(rd1), .tbuf_rd_col_o(rcol1),
    .ena_ht_v_o(ehv1), .ena_sum_o(esum1), .rst_sum_o(rsum1),
`ifdef SATD_BLK_CNT_EN
    .blk_count_o(bc1),
`endif
    .done_o(done1)
  );

  satd_sequencer #(.ROWS(4), .HT_LAT(1), .VT_LAT(3)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .ready_o(rdy2), .row_idx_o(row2),
    .ena_diff_o(ediff2), .ena_ht_h_o(ehh2), .sel_ht_h_o(sel2), .tbuf_wr_o(wr2),
    .tbuf_wr_row_o(wrow2), .tbuf_rd_o(rd2), .tbuf_rd_col_o(rcol2),
    .ena_ht_v_o(ehv2), .ena_sum_o(esum2), .rst_sum_o(rsum2),
`ifdef SATD_BLK_CNT_EN
    .blk_count_o(bc2),
`endif
    .done_o(done2)
  );

  // Spec timeline: accept at cycle 0, c<0 means plain idle.
  // Flags = {ready, rst_sum, ena_diff, ena_ht_h, sel, wr, rd, ena_ht_v, ena_sum, done}
  function automatic logic [9:0] exp_flags(int c, int r, int h, int v);
    int  dc;
    bit  idle, load, wr, rd, sm, dn;
    dc   = 2*r + h + v + 1;
    idle = (c <= 0) || (c > dc);
    load = (c >= 1) && (c <= r);
    wr   = (c >= 1 + h) && (c <= r + h);
    rd   = (c >= r + h + 1) && (c <= 2*r + h);
    sm   = (c >= r + h + 1 + v) && (c <= 2*r + h + v);
    dn   = (c == dc);
    return {idle, idle, load, load, (c == 1), wr, rd, rd, sm, dn};
  endfunction

  task automatic cmp(input string tag, input int c, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s c=%0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic chk1(input int c);
    logic [9:0] f;
    f = exp_flags(c, 8, 2, 2);
    cmp("d1.flags", c, 16'({rdy1, rsum1, ediff1, ehh1, sel1, wr1, rd1, ehv1, esum1, done1}), 16'(f));
    cmp("d1.row_idx", c, 16'(row1), (c >= 1 && c <= 8) ? 16'(c - 1) : 16'd0);
    cmp("d1.wr_row", c, 16'(wrow1), (c >= 3 && c <= 10) ? 16'(c - 3) : 16'd0);
    cmp("d1.rd_col", c, 16'(rcol1), (c >= 11 && c <= 18) ? 16'(c - 11) : 16'd0);
  endtask

  task automatic chk2(input int c);
    logic [9:0] f;
    f = exp_flags(c, 4, 1, 3);
    cmp("d2.flags", c, 16'({rdy2, rsum2, ediff2, ehh2, sel2, wr2, rd2, ehv2, esum2, done2}), 16'(f));
    cmp("d2.row_idx", c, 16'(row2), (c >= 1 && c <= 4) ? 16'(c - 1) : 16'd0);
    cmp("d2.wr_row", c, 16'(wrow2), (c >= 2 && c <= 5) ? 16'(c - 2) : 16'd0);
    cmp("d2.rd_col", c, 16'(rcol2), (c >= 6 && c <= 9) ? 16'(c - 6) : 16'd0);
  endtask

  // One default block on dut1: accept in cycle 0, check through cycle 22.
  task automatic run_block1();
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      start1 = (c == 0);
      chk1(c);
    end
    start1 = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset, held 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1(-1);
      chk2(-1);
    end

    // Single block on both instances simultaneously.
    wr2_cnt  = 0;
    sum2_cnt = 0;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      start1 = (c == 0);
      start2 = (c == 0);
      chk1(c);
      chk2(c);
      wr2_cnt  += int'(wr2);
      sum2_cnt += int'(esum2);
    end
    start1 = 1'b0;
    start2 = 1'b0;
    cmp("d2.wr_pulses", 0, 16'(wr2_cnt), 16'd4);
    cmp("d2.sum_pulses", 0, 16'(sum2_cnt), 16'd4);

    // Start held high: accepts in cycles 0 and 22 only.
    for (int c = 0; c <= 43; c++) begin
      @(negedge clk);
      start1 = 1'b1;
      chk1(c % 22);
    end
    @(negedge clk);
    start1 = 1'b0;
    chk1(0);
    @(negedge clk);
    chk1(-1);

    // Reset in cycle 12 (VERT); cycle 13 must be idle.
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      start1 = (c == 0);
      chk1(c);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1(-1);
    chk2(-1);
    @(negedge clk);
    chk1(-1);

    // A fresh block after the abort completes normally.
    run_block1();

`ifdef SATD_BLK_CNT_EN
    cmp("d1.blk_count_1", 0, bc1, 16'd1);
    run_block1();
    run_block1();
    cmp("d1.blk_count_3", 0, bc1, 16'd3);
    @(negedge clk);
    force dut1.blk_count_q = 16'hFFFF;
    @(negedge clk);
    release dut1.blk_count_q;
    cmp("d1.blk_count_pre", 0, bc1, 16'hFFFF);
    run_block1();
    cmp("d1.blk_count_wrap", 0, bc1, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_satd_sequencer
`default_nettype wire
